// File: rtl/mips_mem_pkg.sv
// Shared address decode and byte-lane helpers for the MIPS bench memory models.
// Used by the data-side RAM and, later, the instruction-side model.
package mips_mem_pkg;

    localparam int WORD_BYTES = 4;

    function automatic logic [31:0] index_of(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return (addr - base) >> 2;
    endfunction

    // 64-bit limit so a window ending at the top of the address space still decodes
    function automatic logic in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned depth
    );
        logic [63:0] w_lim;
        w_lim = 64'(base) + 64'(depth) * 64'(WORD_BYTES);
        return (addr >= base) && (64'(addr) < w_lim);
    endfunction

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] w_out;
        w_out = old_w;
        for (int n = 0; n < WORD_BYTES; n++) begin
            if (be[n]) w_out[8*n +: 8] = new_w[8*n +: 8];
        end
        return w_out;
    endfunction

endpackage

// File: rtl/mem_wait_ctrl.sv
// Wait-state sequencer: counts waitrequest cycles for a held request
// and flags the cycle on which the access completes.
module mem_wait_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_active,
    output logic o_wait,
    output logic o_done
);

    localparam logic [3:0] WMAX = 4'(WAIT_CYCLES);

    logic [3:0] r_wcnt;
    logic       w_pending;

    assign w_pending = r_wcnt < WMAX;
    assign o_wait    = !reset && i_active && w_pending;
    assign o_done    = !reset && i_active && !w_pending;

    // A dropped request or a completion both rearm the full wait count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wcnt <= '0;
        end else if (i_active && w_pending) begin
            r_wcnt <= r_wcnt + 4'd1;
        end else begin
            r_wcnt <= '0;
        end
    end

endmodule

// File: rtl/mips_data_ram_wait.sv
// Parametrised data memory for the MIPS CPU benches: wait states,
// byte enables, sticky error flag, access counters and a debug backdoor.
module mips_data_ram_wait
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        data_waitrequest,
    input  logic [31:0] dbg_address,
    input  logic        dbg_write,
    input  logic [31:0] dbg_writedata,
    output logic [31:0] dbg_readdata,
    output logic        err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_active;
    logic          w_wait;
    logic          w_done;
    logic          w_both;
    logic          w_cpu_ok;
    logic          w_aligned;
    logic          w_dbg_ok;
    logic          w_cpu_wr;
    logic          w_dbg_wr;
    logic [IW-1:0] w_cpu_idx;
    logic [IW-1:0] w_dbg_idx;
    logic [31:0]   w_wr_base;

    assign w_active  = data_read ^ data_write;
    assign w_both    = data_read && data_write;
    assign w_cpu_ok  = in_range(data_address, ADDR_BASE, DEPTH_WORDS);
    assign w_dbg_ok  = in_range(dbg_address, ADDR_BASE, DEPTH_WORDS);
    assign w_aligned = data_address[1:0] == 2'b00;
    assign w_cpu_idx = IW'(index_of(data_address, ADDR_BASE));
    assign w_dbg_idx = IW'(index_of(dbg_address, ADDR_BASE));

    mem_wait_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk      (clk),
        .reset    (reset),
        .i_active (w_active),
        .o_wait   (w_wait),
        .o_done   (w_done)
    );

    assign data_waitrequest = w_wait;
    assign w_cpu_wr = w_done && data_write && w_aligned && w_cpu_ok;
    assign w_dbg_wr = dbg_write && w_dbg_ok;

    assign data_readdata = (!reset && data_read && !w_wait && w_cpu_ok)
                         ? r_mem[w_cpu_idx] : '0;
    assign dbg_readdata  = w_dbg_ok ? r_mem[w_dbg_idx] : '0;

    // On a same-word collision the debug data fills the lanes the CPU leaves alone
    assign w_wr_base = (w_dbg_wr && (w_dbg_idx == w_cpu_idx))
                     ? dbg_writedata : r_mem[w_cpu_idx];

    always_ff @(posedge clk) begin
        if (w_dbg_wr) r_mem[w_dbg_idx] <= dbg_writedata;
        if (w_cpu_wr) begin
            r_mem[w_cpu_idx] <= merge_bytes(w_wr_base, data_writedata,
                                            data_byteenable);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err      <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else if (w_both) begin
            err <= 1'b1;
        end else if (w_done) begin
            if (!w_aligned || !w_cpu_ok) err <= 1'b1;
            if (w_aligned) begin
                if (data_read) rd_count <= rd_count + 32'd1;
                else           wr_count <= wr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mips_data_ram_wait.sv
// Randomised self-checking bench for mips_data_ram_wait: three instances
// (2, 0 and 3 wait states) against an array-based reference memory.
module tb_mips_data_ram_wait;

    localparam int N     = 3;
    localparam int DEPTH = 128;
    localparam int TMO   = 40;

    logic        clk;
    logic        rst   [N];
    logic [31:0] addr  [N];
    logic        rd    [N];
    logic        wr    [N];
    logic [3:0]  be    [N];
    logic [31:0] wd    [N];
    logic [31:0] rdata [N];
    logic        wreq  [N];
    logic [31:0] daddr [N];
    logic        dwr   [N];
    logic [31:0] dwd   [N];
    logic [31:0] drd   [N];
    logic        err   [N];
    logic [31:0] rdc   [N];
    logic [31:0] wrc   [N];

    logic [31:0] mdl   [N][DEPTH];
    int unsigned m_rd  [N];
    int unsigned m_wr  [N];
    logic        m_err [N];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mips_data_ram_wait #(
        .ADDR_BASE (32'h0000_0000), .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (2), .INIT_FILE ("")
    ) u_dut0 (
        .clk (clk), .reset (rst[0]),
        .data_address (addr[0]), .data_read (rd[0]), .data_write (wr[0]),
        .data_byteenable (be[0]), .data_writedata (wd[0]),
        .data_readdata (rdata[0]), .data_waitrequest (wreq[0]),
        .dbg_address (daddr[0]), .dbg_write (dwr[0]),
        .dbg_writedata (dwd[0]), .dbg_readdata (drd[0]),
        .err (err[0]), .rd_count (rdc[0]), .wr_count (wrc[0])
    );

    mips_data_ram_wait #(
        .ADDR_BASE (32'h0000_0000), .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (0), .INIT_FILE ("")
    ) u_dut1 (
        .clk (clk), .reset (rst[1]),
        .data_address (addr[1]), .data_read (rd[1]), .data_write (wr[1]),
        .data_byteenable (be[1]), .data_writedata (wd[1]),
        .data_readdata (rdata[1]), .data_waitrequest (wreq[1]),
        .dbg_address (daddr[1]), .dbg_write (dwr[1]),
        .dbg_writedata (dwd[1]), .dbg_readdata (drd[1]),
        .err (err[1]), .rd_count (rdc[1]), .wr_count (wrc[1])
    );

    mips_data_ram_wait #(
        .ADDR_BASE (32'h0000_1000), .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (3), .INIT_FILE ("")
    ) u_dut2 (
        .clk (clk), .reset (rst[2]),
        .data_address (addr[2]), .data_read (rd[2]), .data_write (wr[2]),
        .data_byteenable (be[2]), .data_writedata (wd[2]),
        .data_readdata (rdata[2]), .data_waitrequest (wreq[2]),
        .dbg_address (daddr[2]), .dbg_write (dwr[2]),
        .dbg_writedata (dwd[2]), .dbg_readdata (drd[2]),
        .err (err[2]), .rd_count (rdc[2]), .wr_count (wrc[2])
    );

    function automatic logic [31:0] base_of(input int k);
        return (k == 2) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction

    function automatic int wc(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic bit inr(input int k, input logic [31:0] a);
        if (a < base_of(k)) return 1'b0;
        return (a - base_of(k)) < 32'(DEPTH * 4);
    endfunction

    function automatic int widx(input int k, input logic [31:0] a);
        return int'((a - base_of(k)) >> 2);
    endfunction

    function automatic logic [31:0] mdl_rd(input int k, input logic [31:0] a);
        if (!inr(k, a)) return 32'h0;
        return mdl[k][widx(k, a)];
    endfunction

    task automatic dbg_wr(input int k, input logic [31:0] a,
                          input logic [31:0] d);
        @(negedge clk);
        daddr[k] = a; dwd[k] = d; dwr[k] = 1'b1;
        @(posedge clk);
        #1 dwr[k] = 1'b0;
        if (inr(k, a)) mdl[k][widx(k, a)] = d;
    endtask

    task automatic dbg_rd(input int k, input logic [31:0] a,
                          output logic [31:0] d);
        daddr[k] = a;
        #1 d = drd[k];
    endtask

    task automatic pulse_reset(input int k);
        @(negedge clk);
        rst[k] = 1'b1;
        @(negedge clk);
        rst[k] = 1'b0;
        m_rd[k] = 0; m_wr[k] = 0; m_err[k] = 1'b0;
    endtask

    // Applies the model's view of a completed access
    task automatic mdl_commit(input int k, input bit is_rd,
                              input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] d);
        if (a[1:0] != 2'b00) begin
            m_err[k] = 1'b1;
        end else begin
            if (!inr(k, a)) m_err[k] = 1'b1;
            if (is_rd) begin
                m_rd[k]++;
            end else begin
                m_wr[k]++;
                if (inr(k, a)) begin
                    for (int n = 0; n < 4; n++)
                        if (b[n]) mdl[k][widx(k, a)][8*n +: 8] = d[8*n +: 8];
                end
            end
        end
    endtask

    task automatic cpu_access(input int k, input bit is_rd,
                              input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] d,
                              output logic [31:0] got, output int waits);
        @(negedge clk);
        addr[k] = a; be[k] = b; wd[k] = d;
        rd[k] = is_rd; wr[k] = !is_rd;
        #1 waits = 0;
        while (wreq[k] !== 1'b0 && waits < TMO) begin
            waits++;
            @(negedge clk);
            #1;
        end
        got = rdata[k];
        @(posedge clk);
        #1 rd[k] = 1'b0; wr[k] = 1'b0;
        mdl_commit(k, is_rd, a, b, d);
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) begin
            rd[k] = 1'b1; addr[k] = base_of(k);
        end
        #12;
        for (int k = 0; k < N; k++) begin
            total++;
            if (wreq[k] !== 1'b0 || rdata[k] !== 32'h0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: wait=%b rdata=%h want 0/0",
                         k, wreq[k], rdata[k]);
            end
            total++;
            if (err[k] !== 1'b0 || rdc[k] !== 32'h0 || wrc[k] !== 32'h0) begin
                bad++;
                $display("FAIL reset_state[%0d]: err=%b rd=%0d wr=%0d want 0",
                         k, err[k], rdc[k], wrc[k]);
            end
            rd[k] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) rst[k] = 1'b0;
        for (int k = 0; k < N; k++)
            for (int i = 0; i < DEPTH; i++)
                dbg_wr(k, base_of(k) + 32'(4 * i), $urandom);
    endtask

    task automatic test_write_readback();
        logic [31:0] got;
        int          w;
        cpu_access(0, 1'b0, 32'h100, 4'hF, 32'hDEADBEEF, got, w);
        total++;
        if (w !== 2) begin
            bad++;
            $display("FAIL wr_latency: waits=%0d want 2", w);
        end
        cpu_access(0, 1'b1, 32'h100, 4'hF, 32'h0, got, w);
        total++;
        if (got !== 32'hDEADBEEF || w !== 2) begin
            bad++;
            $display("FAIL readback: got %h waits=%0d want deadbeef/2", got, w);
        end
        #1;
        total++;
        if (rdc[0] !== 32'd1 || wrc[0] !== 32'd1) begin
            bad++;
            $display("FAIL wr_rd_counts: rd=%0d wr=%0d want 1/1",
                     rdc[0], wrc[0]);
        end
    endtask

    task automatic test_byte_enables();
        logic [31:0] got;
        int          w;
        dbg_wr(0, 32'h104, 32'h11223344);
        cpu_access(0, 1'b0, 32'h104, 4'b0101, 32'hAABBCCDD, got, w);
        dbg_rd(0, 32'h104, got);
        total++;
        if (got !== 32'h11BB33DD) begin
            bad++;
            $display("FAIL byte_enable: got %h want 11bb33dd", got);
        end
        cpu_access(0, 1'b0, 32'h104, 4'b0000, 32'hFFFFFFFF, got, w);
        dbg_rd(0, 32'h104, got);
        total++;
        if (got !== 32'h11BB33DD || wrc[0] !== 32'(m_wr[0])) begin
            bad++;
            $display("FAIL be_zero: got %h wr=%0d want 11bb33dd/%0d",
                     got, wrc[0], m_wr[0]);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] g0;
        logic [31:0] g1;
        logic        w0;
        logic        w1;
        @(negedge clk);
        addr[1] = 32'h0; rd[1] = 1'b1; be[1] = 4'hF;
        #1 g0 = rdata[1]; w0 = wreq[1];
        @(posedge clk);
        #1 addr[1] = 32'h4;
        #1 g1 = rdata[1]; w1 = wreq[1];
        @(posedge clk);
        #1 rd[1] = 1'b0;
        mdl_commit(1, 1'b1, 32'h0, 4'hF, 32'h0);
        mdl_commit(1, 1'b1, 32'h4, 4'hF, 32'h0);
        total++;
        if (w0 !== 1'b0 || w1 !== 1'b0) begin
            bad++;
            $display("FAIL zero_wait_req: got %b%b want 00", w0, w1);
        end
        total++;
        if (g0 !== mdl[1][0] || g1 !== mdl[1][1]) begin
            bad++;
            $display("FAIL zero_wait_data: got %h %h want %h %h",
                     g0, g1, mdl[1][0], mdl[1][1]);
        end
        total++;
        if (rdc[1] !== 32'd2) begin
            bad++;
            $display("FAIL zero_wait_count: got %0d want 2", rdc[1]);
        end
    endtask

    task automatic test_dbg_collision();
        logic [31:0] got;
        int          w;
        @(negedge clk);
        addr[0] = 32'h108; be[0] = 4'b0011; wd[0] = 32'h55667788;
        wr[0] = 1'b1;
        #1 w = 0;
        while (wreq[0] !== 1'b0 && w < TMO) begin
            w++;
            @(negedge clk);
            #1;
        end
        daddr[0] = 32'h108; dwd[0] = 32'hA1B2C3D4; dwr[0] = 1'b1;
        @(posedge clk);
        #1 wr[0] = 1'b0; dwr[0] = 1'b0;
        mdl[0][66] = 32'hA1B2C3D4;
        mdl_commit(0, 1'b0, 32'h108, 4'b0011, 32'h55667788);
        dbg_rd(0, 32'h108, got);
        total++;
        if (got !== 32'hA1B27788 || w !== 2) begin
            bad++;
            $display("FAIL collision: got %h waits=%0d want a1b27788/2",
                     got, w);
        end
        total++;
        if (wrc[0] !== 32'(m_wr[0]) || rdc[0] !== 32'(m_rd[0])) begin
            bad++;
            $display("FAIL collision_counts: rd=%0d wr=%0d want %0d/%0d",
                     rdc[0], wrc[0], m_rd[0], m_wr[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic [31:0] exp;
        logic [31:0] a;
        int          w;
        int          k;
        bit          is_rd;
        for (int i = 0; i < 60; i++) begin
            k = ($urandom % 2 == 0) ? 0 : 2;
            is_rd = 1'($urandom % 2);
            a = base_of(k) + 32'(4 * $urandom_range(0, DEPTH - 1));
            exp = mdl_rd(k, a);
            cpu_access(k, is_rd, a, 4'($urandom), $urandom, got, w);
            total++;
            if (w !== wc(k) || (is_rd && got !== exp)) begin
                bad++;
                $display("FAIL rand[%0d] k=%0d a=%h: got %h waits=%0d want %h/%0d",
                         i, k, a, got, w, exp, wc(k));
            end
        end
        for (int kk = 0; kk < N; kk += 2) begin
            #1;
            total++;
            if (rdc[kk] !== 32'(m_rd[kk]) || wrc[kk] !== 32'(m_wr[kk])
                || err[kk] !== m_err[kk]) begin
                bad++;
                $display("FAIL rand_counts[%0d]: rd=%0d wr=%0d err=%b want %0d/%0d/%b",
                         kk, rdc[kk], wrc[kk], err[kk],
                         m_rd[kk], m_wr[kk], m_err[kk]);
            end
            for (int i = 0; i < DEPTH; i++) begin
                dbg_rd(kk, base_of(kk) + 32'(4 * i), got);
                total++;
                if (got !== mdl[kk][i]) begin
                    bad++;
                    $display("FAIL rand_mem[%0d][%0d]: got %h want %h",
                             kk, i, got, mdl[kk][i]);
                end
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] got;
        logic [31:0] got2;
        int          w;
        @(negedge clk);
        addr[0] = 32'h100; wd[0] = 32'h0; be[0] = 4'hF;
        rd[0] = 1'b1; wr[0] = 1'b1;
        #1 w = int'(wreq[0]);
        @(posedge clk);
        #1 rd[0] = 1'b0; wr[0] = 1'b0;
        m_err[0] = 1'b1;
        dbg_rd(0, 32'h100, got);
        total++;
        if (err[0] !== 1'b1 || w !== 0 || got !== mdl[0][64]
            || rdc[0] !== 32'(m_rd[0]) || wrc[0] !== 32'(m_wr[0])) begin
            bad++;
            $display("FAIL rd_wr_both: err=%b wait=%0d mem=%h rd=%0d wr=%0d want 1/0/%h/%0d/%0d",
                     err[0], w, got, rdc[0], wrc[0],
                     mdl[0][64], m_rd[0], m_wr[0]);
        end
        pulse_reset(0);
        #1;
        total++;
        if (err[0] !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: got %b want 0", err[0]);
        end
        cpu_access(0, 1'b1, 32'h102, 4'hF, 32'h0, got, w);
        #1;
        total++;
        if (err[0] !== 1'b1 || rdc[0] !== 32'd0) begin
            bad++;
            $display("FAIL misaligned: err=%b rd=%0d want 1/0", err[0], rdc[0]);
        end
        pulse_reset(0);
        cpu_access(0, 1'b0, 32'h200, 4'hF, 32'h0BADF00D, got, w);
        dbg_rd(0, 32'h0, got);
        dbg_rd(0, 32'h200, got2);
        total++;
        if (err[0] !== 1'b1 || got !== mdl[0][0] || got2 !== 32'h0) begin
            bad++;
            $display("FAIL oor_write: err=%b w0=%h dbg=%h want 1/%h/0",
                     err[0], got, got2, mdl[0][0]);
        end
        pulse_reset(0);
        cpu_access(0, 1'b1, 32'h200, 4'hF, 32'h0, got, w);
        total++;
        if (err[0] !== 1'b1 || got !== 32'h0) begin
            bad++;
            $display("FAIL oor_read: err=%b data=%h want 1/0", err[0], got);
        end
        pulse_reset(2);
        cpu_access(2, 1'b0, 32'h0FFC, 4'hF, 32'h0BADF00D, got, w);
        dbg_rd(2, 32'h1000 + 32'(4 * (DEPTH - 1)), got);
        total++;
        if (err[2] !== 1'b1 || got !== mdl[2][DEPTH-1]) begin
            bad++;
            $display("FAIL below_base: err=%b top=%h want 1/%h",
                     err[2], got, mdl[2][DEPTH-1]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] old_w;
        logic [31:0] new_w;
        logic [31:0] got;
        logic        w0;
        int          n;
        pulse_reset(2);
        old_w = mdl[2][4];
        new_w = ~old_w;
        @(negedge clk);
        addr[2] = 32'h1010; be[2] = 4'hF; wd[2] = new_w; wr[2] = 1'b1;
        #1 w0 = wreq[2];
        @(negedge clk);
        wr[2] = 1'b0;
        @(posedge clk);
        dbg_rd(2, 32'h1010, got);
        total++;
        if (w0 !== 1'b1 || got !== old_w || wrc[2] !== 32'd0) begin
            bad++;
            $display("FAIL abort_drop: wait=%b mem=%h wr=%0d want 1/%h/0",
                     w0, got, wrc[2], old_w);
        end
        @(negedge clk);
        wr[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst[2] = 1'b1;
        #1 w0 = wreq[2];
        @(negedge clk);
        rst[2] = 1'b0;
        dbg_rd(2, 32'h1010, got);
        total++;
        if (w0 !== 1'b0 || got !== old_w) begin
            bad++;
            $display("FAIL abort_reset: wait=%b mem=%h want 0/%h",
                     w0, got, old_w);
        end
        n = 0;
        while (wreq[2] !== 1'b0 && n < TMO) begin
            n++;
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1 wr[2] = 1'b0;
        mdl_commit(2, 1'b0, 32'h1010, 4'hF, new_w);
        dbg_rd(2, 32'h1010, got);
        total++;
        if (n !== 3 || got !== new_w || wrc[2] !== 32'd1) begin
            bad++;
            $display("FAIL restart: waits=%0d mem=%h wr=%0d want 3/%h/1",
                     n, got, wrc[2], new_w);
        end
    endtask

    task automatic test_contents_survive();
        logic [31:0] got;
        int          w;
        cpu_access(0, 1'b0, 32'h100, 4'hF, 32'hCAFEF00D, got, w);
        pulse_reset(0);
        #1;
        total++;
        if (rdc[0] !== 32'd0) begin
            bad++;
            $display("FAIL survive_count: got %0d want 0", rdc[0]);
        end
        cpu_access(0, 1'b1, 32'h100, 4'hF, 32'h0, got, w);
        total++;
        if (got !== 32'hCAFEF00D || rdc[0] !== 32'd1) begin
            bad++;
            $display("FAIL survive_data: got %h rd=%0d want cafef00d/1",
                     got, rdc[0]);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; addr[k] = '0; rd[k] = 1'b0; wr[k] = 1'b0;
            be[k] = '0; wd[k] = '0; daddr[k] = '0; dwr[k] = 1'b0;
            dwd[k] = '0; m_rd[k] = 0; m_wr[k] = 0; m_err[k] = 1'b0;
        end
        test_reset();
        test_write_readback();
        test_byte_enables();
        test_zero_wait();
        test_dbg_collision();
        test_random();
        test_errors();
        test_abort();
        test_contents_survive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
